// File: rtl/pwm_gen_pkg.sv
// -----------------------------------------------------------------------------
// pwm_gen_pkg
// Shared definitions for the PWM generator: controller state encoding, the
// default period constant and the duty clamp helper.
// -----------------------------------------------------------------------------
package pwm_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } pwm_state_t;

    // 1 ms period at a 50 MHz system clock
    localparam logic [15:0] PWM_PERIOD_DEFAULT = 16'd50000;

    // Limit a requested duty to the period length
    function automatic logic [15:0] clamp_duty(input logic [15:0] d,
                                               input logic [15:0] p);
        return (d > p) ? p : d;
    endfunction

endpackage

// File: rtl/pwm_gen_period_cnt.sv
// -----------------------------------------------------------------------------
// pwm_period_cnt
// Wrapping period counter for the PWM generator. Counts 0..PERIOD-1 while
// enabled and is held at zero while disabled.
//
// Ports
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset
//   i_en    : count enable
//   o_cnt   : current count value
//   o_wrap  : high in the cycle where the counter sits at PERIOD-1 while
//             enabled, i.e. the next edge wraps it to zero
// -----------------------------------------------------------------------------
module pwm_period_cnt
    import pwm_gen_pkg::*;
#(
    parameter logic [15:0] PERIOD = PWM_PERIOD_DEFAULT
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    output logic [15:0] o_cnt,
    output logic        o_wrap
);

    logic [15:0] r_cnt;
    logic        w_last;

    assign w_last = (r_cnt == PERIOD - 16'd1);
    assign o_wrap = i_en && w_last;
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 16'd0;
        end else if (!i_en || w_last) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen
// Single-channel PWM generator. A three-state controller (IDLE/RUN/STOP)
// drives a wrapping period counter; the duty request is latched only at
// period boundaries so mid-period changes never glitch the waveform.
//
// Parameters
//   PERIOD      : clocks per PWM period
//   ACTIVE_HIGH : 1 = pwm active high, 0 = pwm active low
//
// Ports
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset
//   en           : run request
//   duty         : requested active time in clocks (0..PERIOD)
//   pwm          : registered PWM waveform
//   period_end   : one-clock pulse after each period wrap
//   duty_clamped : the duty in use was clamped to PERIOD
//   busy         : controller is not idle
// -----------------------------------------------------------------------------
module pwm_gen
    import pwm_gen_pkg::*;
#(
    parameter logic [15:0] PERIOD      = PWM_PERIOD_DEFAULT,
    parameter bit          ACTIVE_HIGH = 1'b1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] duty,
    output logic        pwm,
    output logic        period_end,
    output logic        duty_clamped,
    output logic        busy
);

    localparam logic PWM_OFF = ACTIVE_HIGH ? 1'b0 : 1'b1;

    pwm_state_t  r_state;
    logic [15:0] r_duty_q;
    logic        r_duty_clamped;
    logic        r_busy;
    logic        r_pwm;
    logic        r_period_end;

    logic [15:0] w_cnt;
    logic        w_wrap;
    logic        w_cnt_en;
    logic        w_pwm_act;
    logic [15:0] w_duty_load;
    logic        w_duty_over;

    // The counter only runs outside IDLE, so it is already zero on entry to RUN
    assign w_cnt_en = (r_state != ST_IDLE);

    pwm_period_cnt #(
        .PERIOD (PERIOD)
    ) u_period_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_cnt_en),
        .o_cnt  (w_cnt),
        .o_wrap (w_wrap)
    );

    assign w_duty_over = (duty > PERIOD);
    assign w_duty_load = clamp_duty(duty, PERIOD);
    assign w_pwm_act   = w_cnt_en && (w_cnt < r_duty_q);

    // Controller, duty latch and busy flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_duty_q       <= 16'd0;
            r_duty_clamped <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_state        <= ST_RUN;
                        r_busy         <= 1'b1;
                        r_duty_q       <= w_duty_load;
                        r_duty_clamped <= w_duty_over;
                    end
                end
                ST_RUN: begin
                    if (w_wrap) begin
                        r_duty_q       <= w_duty_load;
                        r_duty_clamped <= w_duty_over;
                    end
                    if (!en) begin
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_wrap) begin
                        r_duty_q       <= w_duty_load;
                        r_duty_clamped <= w_duty_over;
                        if (en) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (en) begin
                        // Re-request before the wrap: keep the period running
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output waveform registers, one clock behind the counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm        <= PWM_OFF;
            r_period_end <= 1'b0;
        end else begin
            r_pwm        <= w_pwm_act ? ~PWM_OFF : PWM_OFF;
            r_period_end <= w_wrap;
        end
    end

    assign pwm          = r_pwm;
    assign period_end   = r_period_end;
    assign duty_clamped = r_duty_clamped;
    assign busy         = r_busy;

endmodule

// File: tb/tb_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_gen
// Self-checking bench for pwm_gen with PERIOD=10. Two instances share the
// stimulus: one active-high, one active-low. A behavioural model tracks the
// run mode, position within the period and the latched duty.
// -----------------------------------------------------------------------------
module tb_pwm_gen;

    localparam int          PI = 10;
    localparam logic [15:0] P  = 16'd10;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] duty;
    logic        pwm, pe, dc, busy;
    logic        pwm_n, pe_n, dc_n, busy_n;

    always #5 clk = ~clk;

    pwm_gen #(.PERIOD(P), .ACTIVE_HIGH(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .duty(duty),
        .pwm(pwm), .period_end(pe), .duty_clamped(dc), .busy(busy)
    );

    pwm_gen #(.PERIOD(P), .ACTIVE_HIGH(1'b0)) dut_n (
        .clk(clk), .rst(rst), .en(en), .duty(duty),
        .pwm(pwm_n), .period_end(pe_n), .duty_clamped(dc_n), .busy(busy_n)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model
    typedef enum {M_IDLE, M_RUN, M_STOP} mode_t;
    mode_t m_mode;
    int    m_pos;
    int    m_dq;
    bit    m_clamp;
    bit    m_act;
    bit    m_pe;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_pos   = 0;
        m_dq    = 0;
        m_clamp = 1'b0;
        m_act   = 1'b0;
        m_pe    = 1'b0;
    endtask

    task automatic model_load();
        m_clamp = (int'(duty) > PI);
        m_dq    = m_clamp ? PI : int'(duty);
    endtask

    // One rising edge: outputs reflect the state before the edge
    task automatic model_edge();
        bit live;
        bit wrap;
        live  = (m_mode != M_IDLE);
        wrap  = live && (m_pos == PI - 1);
        m_act = live && (m_pos < m_dq);
        m_pe  = wrap;
        if (!live) begin
            if (en) begin
                m_mode = M_RUN;
                model_load();
            end
        end else if (wrap) begin
            m_pos = 0;
            model_load();
            if (en)                   m_mode = M_RUN;
            else if (m_mode == M_RUN) m_mode = M_STOP;
            else                      m_mode = M_IDLE;
        end else begin
            m_pos++;
            m_mode = en ? M_RUN : M_STOP;
        end
    endtask

    task automatic check_outputs();
        chk("pwm",          16'(pwm),   16'(m_act));
        chk("pwm_low_act",  16'(pwm_n), 16'(!m_act));
        chk("period_end",   16'(pe),    16'(m_pe));
        chk("period_end_n", 16'(pe_n),  16'(m_pe));
        chk("duty_clamped", 16'(dc),    16'(m_clamp));
        chk("busy",         16'(busy),  16'(m_mode != M_IDLE));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_edge();
        else     model_reset();
        #1;
        check_outputs();
    endtask

    task automatic wait_pe();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            cycle();
            found = (pe === 1'b1);
        end
        chk("period_end_seen", 16'(found), 16'd1);
    endtask

    // Starting at a period_end sample (count 0), run one full period and
    // tally the samples belonging to it. Step i leaves the counter at i.
    task automatic count_period(input int duty_step, input int new_duty,
                                input int off_step, input int on_step,
                                output int highs, output int lows_n,
                                output int pes, output int all_busy);
        highs    = 0;
        lows_n   = 0;
        pes      = 0;
        all_busy = 1;
        for (int i = 1; i <= PI; i++) begin
            cycle();
            highs  += int'(pwm === 1'b1);
            lows_n += int'(pwm_n === 1'b0);
            pes    += int'(pe === 1'b1);
            if (busy !== 1'b1) all_busy = 0;
            if (i == duty_step) duty = 16'(new_duty);
            if (i == off_step)  en = 1'b0;
            if (i == on_step)   en = 1'b1;
        end
        chk("period_end_at_wrap", 16'(pe), 16'd1);
    endtask

    int h, l, np, ab;

    initial begin
        rst  = 1'b0;
        en   = 1'b0;
        duty = 16'd0;
        model_reset();

        // Reset state
        repeat (3) cycle();
        chk("reset_busy", 16'(busy), 16'd0);
        chk("reset_pwm_n_level", 16'(pwm_n), 16'd1);

        // Basic run with duty 3
        rst  = 1'b1;
        en   = 1'b1;
        duty = 16'd3;
        wait_pe();
        count_period(0, 0, 0, 0, h, l, np, ab);
        chk("duty3_highs", 16'(h), 16'd3);
        chk("duty3_pe_count", 16'(np), 16'd1);
        chk("duty3_not_clamped", 16'(dc), 16'd0);

        // Duty change mid-period is deferred to the next period
        count_period(5, 7, 0, 0, h, l, np, ab);
        chk("duty_change_cur", 16'(h), 16'd3);
        count_period(0, 0, 0, 0, h, l, np, ab);
        chk("duty_change_next", 16'(h), 16'd7);

        // Duty 0, full period, over-range
        duty = 16'd0;
        count_period(0, 0, 0, 0, h, l, np, ab);
        count_period(0, 0, 0, 0, h, l, np, ab);
        chk("duty0_highs", 16'(h), 16'd0);
        duty = 16'd10;
        count_period(0, 0, 0, 0, h, l, np, ab);
        count_period(0, 0, 0, 0, h, l, np, ab);
        chk("duty10_highs", 16'(h), 16'd10);
        chk("duty10_pwm_at_wrap", 16'(pwm), 16'd1);
        duty = 16'd12;
        count_period(0, 0, 0, 0, h, l, np, ab);
        count_period(0, 0, 0, 0, h, l, np, ab);
        chk("duty12_highs", 16'(h), 16'd10);
        chk("duty12_clamped", 16'(dc), 16'd1);

        // Active-low instance with duty 4
        duty = 16'd4;
        count_period(0, 0, 0, 0, h, l, np, ab);
        count_period(0, 0, 0, 0, h, l, np, ab);
        chk("active_low_lows", 16'(l), 16'd4);
        chk("active_low_pe_n", 16'(pe_n), 16'd1);
        chk("duty4_unclamped", 16'(dc), 16'd0);

        // Drop en at count 4: period completes, then idle
        count_period(0, 0, 4, 0, h, l, np, ab);
        chk("stop_final_pe", 16'(pe), 16'd1);
        chk("stop_idle_busy", 16'(busy), 16'd0);
        repeat (3) cycle();
        chk("idle_pwm", 16'(pwm), 16'd0);

        // Restart; drop en at 2 and re-raise at 7: no gap
        en = 1'b1;
        wait_pe();
        count_period(0, 0, 2, 7, h, l, np, ab);
        chk("reraise_busy_all", 16'(ab), 16'd1);
        chk("reraise_highs", 16'(h), 16'd4);
        count_period(0, 0, 0, 0, h, l, np, ab);
        chk("reraise_next_busy", 16'(ab), 16'd1);

        // Reset mid-period with pwm active
        duty = 16'd8;
        wait_pe();
        repeat (6) cycle();
        chk("pre_reset_pwm", 16'(pwm), 16'd1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_no_pe", 16'(pe), 16'd0);
        repeat (3) cycle();
        rst = 1'b1;
        en  = 1'b0;
        repeat (4) cycle();
        chk("post_reset_idle", 16'(busy), 16'd0);
        en = 1'b1;

        // Randomized run against the model
        for (int n = 0; n < 600; n++) begin
            cycle();
            if ($urandom_range(0, 9) == 0) en = ~en;
            if ($urandom_range(0, 3) == 0) duty = 16'($urandom_range(0, 13));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 SHALL have parameter PERIOD, default 16'd50000, meaning clocks per PWM period (1 ms at 50 MHz).
REQ-002 SHALL have parameter ACTIVE_HIGH, default 1, meaning pwm active level (1 = high, 0 = low).
REQ-003 SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  run request from control logic.
REQ-006 SHALL have port duty  input  16  requested high time in clocks, driven by the upstream duty generator (0..PERIOD).
REQ-007 SHALL have port pwm  output  1  registered PWM waveform to LED driver.
REQ-008 SHALL have port period_end  output  1  one-clock pulse at each period wrap.
REQ-009 SHALL have port duty_clamped  output  1  high for a whole period when the latched duty exceeded PERIOD.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, RUN, STOP.
REQ-012 IDLE: cnt held 0, pwm inactive, no period_end; en=1 -> RUN at next edge, latching duty into duty_q on that edge.
REQ-013 RUN: cnt increments by 1 per clock; at cnt==PERIOD-1, cnt wraps to 0; en=0 -> STOP (cnt keeps counting).
REQ-014 STOP: finishes current period; at wrap, en=0 -> IDLE, en=1 -> RUN; en=1 before wrap -> RUN with no interruption of cnt.
REQ-015 duty_q SHALL load only at IDLE->RUN and at each wrap in RUN or STOP; duty changes mid-period SHALL be ignored (glitch-free update).
REQ-016 Load rule: duty > PERIOD -> duty_q = PERIOD, duty_clamped = 1 until next load; otherwise duty_q = duty, duty_clamped = 0.
REQ-017 pwm SHALL be registered: active in the cycle after each cycle where state != IDLE and cnt < duty_q; inactive otherwise (one-clock latency from cnt).
REQ-018 High time per period SHALL equal exactly duty_q clocks; duty_q=0 -> never active, duty_q=PERIOD -> continuously active across wraps.
REQ-019 period_end SHALL be registered, high for exactly one clock following each wrap edge, including the final wrap STOP->IDLE.
REQ-020 Active level: ACTIVE_HIGH=0 SHALL invert pwm only; period_end, busy, duty_clamped stay active-high.
REQ-021 cnt width 16 bits, unsigned compare; no arithmetic overflow for PERIOD <= 65535.

Reset
REQ-022 rst=0 SHALL immediately force state=IDLE, cnt=0, duty_q=0, pwm inactive level, period_end=0, duty_clamped=0, busy=0.
REQ-023 Reset asserted mid-period SHALL abort the period with no period_end; after release block waits in IDLE for en.

Structure
REQ-024 State encoding (IDLE/RUN/STOP) and default PERIOD constant SHALL live in the shared project package/header.
REQ-025 A single sub-module pwm_period_cnt (wrapping counter with enable, wrap flag) is natural; FSM, duty latch and compare stay in pwm_gen.

Verification (PERIOD=10 for simulation)
REQ-026 Reset, en=1, duty=3 -> pwm active 3 of every 10 clocks, period_end every 10 clocks, duty_clamped=0.
REQ-027 duty 3->7 at cnt=5 -> current period keeps 3 high clocks, next period 7 high clocks.
REQ-028 duty=0 then duty=10 then duty=12 -> 0 high clocks; continuous active; continuous active with duty_clamped=1.
REQ-029 en dropped at cnt=4 -> period completes, period_end pulses, IDLE, busy=0; en re-raised at cnt=7 of another period -> no gap, stays RUN.
REQ-030 rst asserted at cnt=6, pwm active (duty=8) -> pwm inactive and all outputs reset immediately, no period_end.
REQ-031 ACTIVE_HIGH=0, duty=4 -> pwm low 4 clocks, high 6 clocks per period; period_end unchanged.
